// File: rtl/layer_motion_sequencer.sv
// Per-frame layer motion/animation walker that owns the layer header controller port.
// Optional build macro LAYER_MOTION_SATURATE_EN: saturate X/Y updates instead of wrapping.
module layer_motion_sequencer #(
    parameter int VEL_SHIFT  = 6,
    parameter int NUM_LAYERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frameStart,
    input  logic        hostReq,
    input  logic        hostWrite,
    input  logic [4:0]  hostLayer,
    input  logic [2:0]  hostIndex,
    input  logic [15:0] hostWriteData,
    output logic        hostAck,
    output logic [15:0] hostReadData,
    output logic [4:0]  hdrLayer,
    output logic [2:0]  hdrIndex,
    output logic [15:0] hdrWriteData,
    output logic        hdrWriteEn,
    input  logic [15:0] hdrReadData,
    output logic        busy,
    output logic        updateDone,
    output logic        frameOverrun
);

    typedef enum logic [3:0] {
        IDLE, HOST, RD_FLAGS, RD_X, RD_Y, RD_VX, RD_VY, RD_ANIM,
        WR_X, WR_Y, WR_ANIM, NEXT, DONE
    } state_t;

    localparam logic [4:0] LAST_LAYER = 5'(NUM_LAYERS - 1);

    state_t      state_reg, state_next;
    logic [4:0]  layer_reg;
    logic        pending_reg;
    logic        overrun_reg;
    logic        anim_en_reg;
    logic [15:0] x_reg, y_reg, vx_reg, vy_reg, anim_reg;
    logic        host_ack_reg;
    logic [15:0] host_rdata_reg;

    logic        start_update;
    logic [8:0]  cur_inc;
    logic [7:0]  next_frame;

    function automatic logic [15:0] advance(input logic [15:0] pos, input logic [15:0] vel);
        logic signed [15:0] step;
`ifdef LAYER_MOTION_SATURATE_EN
        logic [16:0] sum;
        step = $signed(vel) >>> VEL_SHIFT;
        sum  = {pos[15], pos} + {step[15], step};
        // A 17-bit result whose top two bits disagree has left the 16-bit range.
        if (sum[16] != sum[15])
            return sum[16] ? 16'h8000 : 16'h7FFF;
        return sum[15:0];
`else
        step = $signed(vel) >>> VEL_SHIFT;
        return pos + step;
`endif
    endfunction

    assign start_update = (state_reg == IDLE) && (frameStart || pending_reg);
    assign cur_inc      = {1'b0, anim_reg[15:8]} + 9'd1;
    assign next_frame   = ((anim_reg[7:0] == 8'd0) || (cur_inc >= {1'b0, anim_reg[7:0]}))
                          ? 8'd0 : cur_inc[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_update)
                    state_next = RD_FLAGS;
                else if (hostReq && !host_ack_reg)
                    state_next = HOST;
            end
            HOST:     state_next = IDLE;
            RD_FLAGS: state_next = (hdrReadData[0] && hdrReadData[1]) ? RD_X : NEXT;
            RD_X:     state_next = RD_Y;
            RD_Y:     state_next = RD_VX;
            RD_VX:    state_next = RD_VY;
            RD_VY:    state_next = RD_ANIM;
            RD_ANIM:  state_next = WR_X;
            WR_X:     state_next = WR_Y;
            WR_Y:     state_next = anim_en_reg ? WR_ANIM : NEXT;
            WR_ANIM:  state_next = NEXT;
            NEXT:     state_next = (layer_reg == LAST_LAYER) ? DONE : RD_FLAGS;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        hdrLayer     = 5'd0;
        hdrIndex     = 3'd0;
        hdrWriteData = 16'd0;
        hdrWriteEn   = 1'b0;
        updateDone   = 1'b0;
        case (state_reg)
            HOST: begin
                hdrLayer     = hostLayer;
                hdrIndex     = hostIndex;
                hdrWriteData = hostWriteData;
                hdrWriteEn   = hostWrite;
            end
            RD_FLAGS: begin hdrLayer = layer_reg; hdrIndex = 3'd0; end
            RD_X:     begin hdrLayer = layer_reg; hdrIndex = 3'd3; end
            RD_Y:     begin hdrLayer = layer_reg; hdrIndex = 3'd4; end
            RD_VX:    begin hdrLayer = layer_reg; hdrIndex = 3'd5; end
            RD_VY:    begin hdrLayer = layer_reg; hdrIndex = 3'd6; end
            RD_ANIM:  begin hdrLayer = layer_reg; hdrIndex = 3'd7; end
            WR_X: begin
                hdrLayer     = layer_reg;
                hdrIndex     = 3'd3;
                hdrWriteData = advance(x_reg, vx_reg);
                hdrWriteEn   = 1'b1;
            end
            WR_Y: begin
                hdrLayer     = layer_reg;
                hdrIndex     = 3'd4;
                hdrWriteData = advance(y_reg, vy_reg);
                hdrWriteEn   = 1'b1;
            end
            WR_ANIM: begin
                hdrLayer     = layer_reg;
                hdrIndex     = 3'd7;
                hdrWriteData = {next_frame, anim_reg[7:0]};
                hdrWriteEn   = 1'b1;
            end
            DONE:     updateDone = 1'b1;
            default:  ;
        endcase
    end

    assign busy         = (state_reg != IDLE);
    assign hostAck      = host_ack_reg;
    assign hostReadData = host_rdata_reg;
    assign frameOverrun = overrun_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            layer_reg      <= 5'd0;
            pending_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
            anim_en_reg    <= 1'b0;
            x_reg          <= 16'd0;
            y_reg          <= 16'd0;
            vx_reg         <= 16'd0;
            vy_reg         <= 16'd0;
            anim_reg       <= 16'd0;
            host_ack_reg   <= 1'b0;
            host_rdata_reg <= 16'd0;
        end else begin
            // Only one frame may queue behind a running update; further pulses are lost.
            if (busy && frameStart) begin
                if (pending_reg)
                    overrun_reg <= 1'b1;
                else
                    pending_reg <= 1'b1;
            end else if (start_update) begin
                pending_reg <= 1'b0;
            end

            if (start_update)
                layer_reg <= 5'd0;
            else if (state_reg == NEXT && layer_reg != LAST_LAYER)
                layer_reg <= layer_reg + 5'd1;

            host_ack_reg <= (state_reg == HOST);
            if (state_reg == HOST)
                host_rdata_reg <= hostWrite ? 16'd0 : hdrReadData;

            case (state_reg)
                RD_FLAGS: anim_en_reg <= hdrReadData[3];
                RD_X:     x_reg       <= hdrReadData;
                RD_Y:     y_reg       <= hdrReadData;
                RD_VX:    vx_reg      <= hdrReadData;
                RD_VY:    vy_reg      <= hdrReadData;
                RD_ANIM:  anim_reg    <= hdrReadData;
                default:  ;
            endcase
        end
    end

endmodule

// File: doc/layer_motion_sequencer.md
Name: layer_motion_sequencer

Overview:
- Sole writer of the layer header memory's controller port (32 layers × 8 × 16-bit registers).
- On each frame-start pulse it walks all 32 layers and writes updated positions and animation frames back before pixel processing begins: X/Y position += velocity; animated sprites advance their current frame.
- Between updates it serves single-register host (CPU) read/write requests to the same port.

Parameters:
- VEL_SHIFT, 6, per-frame position step = velocity >>> VEL_SHIFT (arithmetic shift); 6 ≈ pixels/second at 64 Hz.
- NUM_LAYERS, 32, layers walked per update; fixed to match the 5-bit layer index.

Ports:
- clk  in  1  GPU clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- frameStart  in  1  one-cycle pulse at start of frame
- hostReq  in  1  host access request; held until hostAck
- hostWrite  in  1  1 = write, 0 = read
- hostLayer  in  5  host target layer
- hostIndex  in  3  host target register index
- hostWriteData  in  16  host write data
- hostAck  out  1  one-cycle completion pulse
- hostReadData  out  16  read data, valid with hostAck
- hdrLayer  out  5  to header ctrlReadWriteLayer
- hdrIndex  out  3  to header layerRegisterIndex
- hdrWriteData  out  16  to header writeLayerData
- hdrWriteEn  out  1  to header writeLayerEn
- hdrReadData  in  16  from header ctrlReadData; combinational in hdrLayer/hdrIndex
- busy  out  1  high while not IDLE
- updateDone  out  1  one-cycle pulse when a full update completes
- frameOverrun  out  1  sticky; cleared only by reset

Behaviour:
- Reset (reset = 0, async): state IDLE, all outputs 0, pending flag 0, layer counter 0.
- Reads take one cycle: drive hdrLayer/hdrIndex; capture hdrReadData at the clock edge ending that state. Writes take one cycle with hdrWriteEn = 1. hdrWriteEn is 0 in every other state.
- FSM, one cycle per state:
  - IDLE: priority 1 is frameStart or pending → RD_FLAGS, layer = 0, clear pending. Priority 2 is hostReq with hostAck low → HOST.
  - HOST: drive host address/data; hdrWriteEn = hostWrite; capture read. → IDLE. hostAck and hostReadData are registered and appear in the following cycle. hostReadData is 0 after a write.
  - RD_FLAGS (idx 0): if bit0 = 1 and bit1 = 1 (populated sprite) → RD_X, else → NEXT. Hidden sprites (bit2) are still moved.
  - RD_X (3) → RD_Y (4) → RD_VX (5) → RD_VY (6) → RD_ANIM (7) → WR_X.
  - WR_X: write X + (VX >>> VEL_SHIFT), 16-bit two's complement. → WR_Y.
  - WR_Y: same rule for Y. → WR_ANIM if flags bit3, else NEXT.
  - WR_ANIM: write {next, numFrames}, where cur = [15:8], numFrames = [7:0]. next = 0 if numFrames = 0 or cur + 1 ≥ numFrames, else cur + 1. Frame count is preserved. → NEXT.
  - NEXT: if layer = 31 → DONE, else layer + 1 → RD_FLAGS.
  - DONE: updateDone = 1. → IDLE.
- Update latency: 2 cycles per non-sprite layer, 9 per static sprite, 10 per animated sprite, plus 1 (DONE).
  - All 32 layers non-sprite: updateDone exactly 65 cycles after the frameStart edge.
- frameStart while busy: sets pending. If pending is already set: frameOverrun = 1 and the extra pulse is dropped. A pending update starts from IDLE on the next cycle, ahead of host requests.
- frameStart and hostReq together in IDLE: the update wins; the host waits and is served after DONE.
- Host is never serviced mid-update; hostReq stays asserted until hostAck.
- Reset mid-update: abort immediately with no further writes. Partially updated layers keep whatever was already written. The header memory's own reset is separate.

Optional Feature:
- Macro LAYER_MOTION_SATURATE_EN.
  - Defined: WR_X/WR_Y results saturate to [-32768, 32767] using 17-bit signed arithmetic.
  - Undefined: plain 16-bit two's-complement wrap.

Test Plan:
- Sprite layer 2: flags=0x0003, X=100, Y=50, VX=128, VY=-64 → writes X=102, Y=49; no idx-7 write; updateDone at the expected cycle.
- Animated sprite: flags=0x000B, reg7 = cur 3 / numFrames 4 (0x0304) → reg7 = 0x0004. Then cur 1 → 0x0204. numFrames 0 → 0x0000.
- All layers text/unpopulated → zero hdrWriteEn pulses; updateDone 65 cycles after frameStart.
- hostReq write L5 idx3 = 0x1234, then read back → hostAck one cycle after HOST; hostReadData = 0x1234. hostReq together with frameStart → ack only after updateDone.
- Three frameStart pulses during one update → exactly two updates run; frameOverrun = 1 and stays 1.
- X=32767, VX=640 → with macro X=32767; without macro X=-32759. Reset asserted mid-update → hdrWriteEn 0 immediately; busy 0.
